apb_gcd_queue: RTL and testbench

//  APB slave wrapping a parametrised Euclid GCD engine with command and result FIFOs, so software can queue

---
 rtl/apb_gcd_queue.sv | 269 ++++++++++++++++++++++++++
 tb/tb_apb_gcd_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gcd_queue.sv
// apb_gcd_queue: APB slave feeding a subtractive Euclid GCD engine
// through a command FIFO, with a result FIFO and W1C interrupt.
module apb_gcd_queue_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEP = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  assign full  = count == DEP;
  assign empty = count == '0;
  assign rdata = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end
endmodule

module apb_gcd_queue #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 16,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [DATA_W-1:0] i_pwdata,
  output logic [DATA_W-1:0] o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_intr
);
  localparam int IW = ADDR_W - 2;
  localparam int CW = $clog2(CMD_DEPTH) + 1;
  localparam int RW = $clog2(RES_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_CALC, S_PUSH
  } state_t;

  state_t            state;
  logic [1:0]        ctrl;
  logic [1:0]        int_en;
  logic [1:0]        int_stat;
  logic [1:0]        int_stat_n;
  logic [1:0]        w1c;
  logic [OP_W-1:0]   opa;
  logic [OP_W-1:0]   opb;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [OP_W-1:0]   r;
  logic [2*OP_W-1:0] cmd_q;

  logic              q_wr;
  logic [IW-1:0]     q_idx;
  logic [OP_W-1:0]   q_wdata;

  logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [2*OP_W-1:0] cmd_rdata;
  logic [CW-1:0]     cmd_count;
  logic              res_push, res_pop, res_full, res_empty;
  logic [OP_W-1:0]   res_rdata;
  logic [RW-1:0]     res_count;

  logic              en, busy, access, commit, wr_ok, flush, err_c;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rd_c;
  logic [DATA_W-1:0] status;
  logic              unused;

  assign en     = ctrl[0];
  assign busy   = state != S_IDLE;
  assign idx    = i_paddr[ADDR_W-1:2];
  assign access = i_psel & i_penable & ~o_pready;
  assign commit = o_pready & ~o_pslverr;
  assign wr_ok  = commit & q_wr;
  assign unused = ^{i_paddr[1:0], i_pwdata};

  assign status = DATA_W'({8'(res_count), 8'(cmd_count), 3'b000,
                           busy, res_empty, res_full,
                           cmd_empty, cmd_full});

  // Decode is evaluated in the access cycle and frozen for the ack cycle
  always_comb begin
    err_c = 1'b0;
    rd_c  = '0;
    case (int'(idx))
      0: rd_c = DATA_W'(ctrl);
      1: begin
        rd_c  = status;
        err_c = i_pwrite;
      end
      2: rd_c = DATA_W'(opa);
      3: begin
        rd_c  = DATA_W'(opb);
        err_c = i_pwrite & (cmd_full | ~en);
      end
      4: begin
        rd_c  = DATA_W'(res_rdata);
        err_c = i_pwrite | res_empty;
      end
      5: rd_c = DATA_W'(int_en);
      6: rd_c = DATA_W'(int_stat);
      default: err_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= '0;
      q_wr      <= 1'b0;
      q_idx     <= '0;
      q_wdata   <= '0;
    end else begin
      o_pready  <= access;
      o_pslverr <= access & err_c;
      o_prdata  <= (access & ~i_pwrite & ~err_c) ? rd_c : '0;
      if (access) begin
        q_wr    <= i_pwrite;
        q_idx   <= idx;
        q_wdata <= i_pwdata[OP_W-1:0];
      end
    end
  end

  assign cmd_push = wr_ok & (q_idx == IW'(3));
  assign res_pop  = commit & ~q_wr & (q_idx == IW'(4));
  assign flush    = wr_ok & (q_idx == IW'(0)) & en & ~q_wdata[0];
  assign w1c      = (wr_ok && q_idx == IW'(6)) ? q_wdata[1:0] : 2'b00;

  // Hardware set wins over a same-cycle W1C
  assign int_stat_n = (int_stat & ~w1c) |
                      {o_pready & o_pslverr, res_push};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      opa      <= '0;
      opb      <= '0;
      int_en   <= '0;
      int_stat <= '0;
      o_intr   <= 1'b0;
    end else begin
      if (wr_ok && q_idx == IW'(0)) ctrl <= q_wdata[1:0];
      if (wr_ok && q_idx == IW'(2)) opa <= q_wdata;
      if (cmd_push) opb <= q_wdata;
      if (wr_ok && q_idx == IW'(5)) int_en <= q_wdata[1:0];
      int_stat <= int_stat_n;
      o_intr   <= ctrl[1] ? |(int_stat & int_en)
                          : (int_en[0] & ~res_empty) |
                            (int_en[1] & int_stat[1]);
    end
  end

  assign cmd_pop  = (state == S_IDLE) & en & ~cmd_empty & ~flush;
  assign res_push = (state == S_PUSH) & (~res_full | res_pop) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cmd_q <= '0;
      a     <= '0;
      b     <= '0;
      r     <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cmd_pop) begin
          cmd_q <= cmd_rdata;
          state <= S_LOAD;
        end
        S_LOAD: begin
          a     <= cmd_q[2*OP_W-1:OP_W];
          b     <= cmd_q[OP_W-1:0];
          state <= S_CALC;
        end
        S_CALC: begin
          if (a == '0) begin
            r     <= b;
            state <= S_PUSH;
          end else if (b == '0 || a == b) begin
            r     <= a;
            state <= S_PUSH;
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        S_PUSH: if (res_push) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  apb_gcd_queue_fifo #(
    .W     (2*OP_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .wdata ({opa, q_wdata}),
    .rdata (cmd_rdata),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  apb_gcd_queue_fifo #(
    .W     (OP_W),
    .DEPTH (RES_DEPTH)
  ) u_res (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (res_push),
    .pop   (res_pop),
    .wdata (r),
    .rdata (res_rdata),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );
endmodule

// File: tb/tb_apb_gcd_queue.sv
// tb_apb_gcd_queue: scoreboard bench for apb_gcd_queue with a
// queue-level reference model of the command/result path.
module tb_apb_gcd_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, intr;

  apb_gcd_queue #(
    .ADDR_W(8), .DATA_W(32), .OP_W(16),
    .CMD_DEPTH(4), .RES_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_paddr(paddr), .i_psel(psel),
    .i_penable(penable), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .o_prdata(prdata),
    .o_pready(pready), .o_pslverr(pslverr),
    .o_intr(intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned c;
  } job_t;

  job_t        pend[$];
  int unsigned resq[$];
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          en_m, ity_m;
  bit [1:0]    ie_m, st_m;
  int unsigned opa_m, opb_m;

  function automatic int unsigned gcd(int unsigned x, int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pready: got 1 want 0");
      end else begin
        mon_e = exp_q.pop_front();
        check("prdata", prdata, mon_e[31:0]);
        check("pslverr", 32'(pslverr), 32'(mon_e[32]));
      end
    end
  end

  task automatic xfer(input bit wr, input int idx, input logic [31:0] wd,
                      input logic [31:0] ed, input bit ee);
    bit got;
    got = 1'b0;
    exp_q.push_back({ee, (ee || wr) ? 32'h0 : ed});
    if (ee) st_m[1] = 1'b1;
    @(posedge clk); #1;
    paddr = 8'(idx * 4); pwrite = wr; pwdata = wd;
    psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      got = pready;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL apb_timeout idx %0d: got no pready want pready", idx);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Waits long enough for every queued job to finish or stall,
  // then moves finished jobs into the result model.
  task automatic settle();
    int unsigned cyc;
    cyc = 6;
    foreach (pend[i]) cyc += pend[i].c;
    repeat (cyc) @(posedge clk);
    #1;
    while (pend.size() > 0 && resq.size() < 4) begin
      resq.push_back(gcd(pend[0].a, pend[0].b));
      void'(pend.pop_front());
      st_m[0] = 1'b1;
    end
    if (pend.size() > 0) pend[0].c = 0;
  endtask

  function automatic logic [31:0] status_m();
    int cc, rc;
    cc = pend.size() > 0 ? pend.size() - 1 : 0;
    rc = resq.size();
    return {8'h00, 8'(rc), 8'(cc), 3'b000, pend.size() > 0,
            rc == 0, rc == 4, cc == 0, cc == 4};
  endfunction

  task automatic reg_wr(input int idx, input logic [31:0] v);
    bit          e;
    int unsigned bv, m;
    e  = 1'b0;
    bv = v[15:0];
    case (idx)
      0: begin
        if (en_m && !v[0]) begin
          pend.delete();
          resq.delete();
        end
        en_m  = v[0];
        ity_m = v[1];
      end
      2: opa_m = v[15:0];
      3: begin
        if (!en_m || pend.size() >= 5) e = 1'b1;
        else begin
          opb_m = bv;
          m = opa_m > bv ? opa_m : bv;
          pend.push_back('{a: opa_m, b: bv, c: m + 8});
        end
      end
      5: ie_m = v[1:0];
      6: st_m = st_m & ~v[1:0];
      default: e = 1'b1;
    endcase
    xfer(1'b1, idx, v, 32'h0, e);
  endtask

  task automatic reg_rd(input int idx);
    logic [31:0] d;
    bit          e;
    d = '0;
    e = 1'b0;
    case (idx)
      0: d = {30'b0, ity_m, en_m};
      1: d = status_m();
      2: d = opa_m;
      3: d = opb_m;
      4: if (resq.size() == 0) e = 1'b1;
         else d = resq.pop_front();
      5: d = {30'b0, ie_m};
      6: d = {30'b0, st_m};
      default: e = 1'b1;
    endcase
    xfer(1'b0, idx, 32'h0, d, e);
    if (idx == 4 && pend.size() > 0) settle();
  endtask

  task automatic push_pair(input int unsigned x, input int unsigned y);
    reg_wr(2, x);
    reg_wr(3, y);
  endtask

  task automatic chk_intr(input string nm);
    logic w;
    repeat (2) @(posedge clk);
    #1;
    w = ity_m ? |(st_m & ie_m)
              : (ie_m[0] && resq.size() > 0) || (ie_m[1] && st_m[1]);
    check(nm, 32'(intr), 32'(w));
  endtask

  task automatic model_reset();
    pend.delete();
    resq.delete();
    en_m = 0; ity_m = 0; ie_m = 0; st_m = 0;
    opa_m = 0; opb_m = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_prdata", prdata, 32'h0);

    // reset while the engine is mid-calculation
    reg_wr(0, 3);
    reg_wr(5, 3);
    reg_wr(1, 0);
    chk_intr("intr_err_sticky");
    push_pair(200, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_intr", 32'(intr), 32'h0);
    check("arst_pready", 32'(pready), 32'h0);
    check("arst_prdata", prdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    reg_rd(1);
    reg_rd(0);
    reg_rd(6);

    // single operation and empty-pop error
    reg_wr(0, 1);
    push_pair(48, 18);
    settle();
    reg_rd(6);
    reg_rd(4);
    reg_rd(4);
    reg_rd(6);
    reg_wr(6, 3);

    // queue, full command FIFO with stalled engine
    push_pair(12, 8);
    push_pair(0, 9);
    push_pair(7, 7);
    push_pair(0, 0);
    push_pair(65535, 1);
    settle();
    reg_rd(1);
    push_pair(30, 12);
    push_pair(21, 14);
    push_pair(5, 0);
    push_pair(9, 6);
    settle();
    reg_rd(1);
    reg_wr(3, 77);
    reg_rd(1);
    reg_rd(3);

    // backpressure release and full drain
    reg_rd(4);
    reg_rd(1);
    while (resq.size() > 0) reg_rd(4);
    reg_rd(4);
    reg_rd(1);

    // interrupt modes
    reg_wr(6, 3);
    reg_wr(0, 3);
    reg_wr(5, 3);
    chk_intr("intr_idle");
    push_pair(48, 18);
    settle();
    chk_intr("intr_done_sticky");
    reg_wr(6, 1);
    chk_intr("intr_w1c");
    reg_wr(0, 1);
    chk_intr("intr_level_nonempty");
    push_pair(10, 4);
    settle();
    reg_wr(6, 3);
    chk_intr("intr_level_after_w1c");
    reg_rd(4);
    chk_intr("intr_level_one_left");
    reg_rd(4);
    chk_intr("intr_level_empty");

    // errors and flush on disable
    reg_wr(1, 5);
    reg_rd(9);
    reg_wr(4, 0);
    reg_rd(6);
    for (int i = 0; i < 5; i++)
      push_pair($urandom_range(1, 20), $urandom_range(1, 20));
    settle();
    push_pair(14, 21);
    push_pair(3, 9);
    settle();
    reg_rd(1);
    reg_wr(0, 0);
    reg_rd(1);
    reg_wr(3, 5);
    reg_wr(0, 1);
    push_pair(9, 6);
    settle();
    reg_rd(2);
    reg_rd(4);
    reg_wr(6, 3);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: if (pend.size() < 5)
          push_pair($urandom_range(0, 31), $urandom_range(0, 31));
        2: begin
          settle();
          reg_rd(4);
        end
        3: begin
          settle();
          reg_rd(1);
        end
        default: begin
          reg_rd(2);
          reg_rd(3);
        end
      endcase
    end
    settle();
    while (resq.size() > 0) reg_rd(4);
    reg_rd(1);

    repeat (5) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
